// File: rtl/clk_gate_ctrl.sv
// Per-lane enable generator for a gated register bank: a lane gates after IDLE_CYC no-change
// edges and its enable reopens combinationally the moment its data differs from the held value.
module clk_gate_ctrl #(
   parameter int LANES    = 5,
   parameter int IDLE_CYC = 4,
   parameter int CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [LANES-1:0] D_IN,
   input  logic [LANES-1:0] Q_HELD,
   input  logic             FORCE_ON,
   output logic [LANES-1:0] EN_OUT,
   output logic [LANES-1:0] GATED,
   output logic [LANES-1:0] WAKE,
   output logic [CNT_W-1:0] SAVE_CNT
);

   localparam int IW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC + 1) : 1;
   localparam int PW = $clog2(LANES + 1);
   localparam int SW = CNT_W + PW;
   localparam logic [IW-1:0] LAST_CNT = IW'(IDLE_CYC - 1);
   localparam logic [SW-1:0] SAT_VAL  = {{PW{1'b0}}, {CNT_W{1'b1}}};

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_COUNT = 2'd1,
      ST_GATED = 2'd2
   } state_t;

   state_t           state_q [LANES];
   state_t           state_d [LANES];
   logic [IW-1:0]    cnt_q   [LANES];
   logic [IW-1:0]    cnt_d   [LANES];
   logic [LANES-1:0] gated_q, gated_d;
   logic [LANES-1:0] wake_q, wake_d;
   logic [CNT_W-1:0] save_q, save_d;
   logic [LANES-1:0] diff;
   logic [PW-1:0]    pop;
   logic [SW-1:0]    sum;

   assign diff   = D_IN ^ Q_HELD;
   // Enable stays open during reset and reopens the same cycle data moves.
   assign EN_OUT = {LANES{~RST_N | FORCE_ON}} | ~gated_q | diff;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         if (FORCE_ON) begin
            state_d[i] = ST_RUN;
            cnt_d[i]   = '0;
         end else begin
            case (state_q[i])
               ST_RUN: begin
                  if (!diff[i]) begin
                     if (IDLE_CYC == 1) begin
                        state_d[i] = ST_GATED;
                     end else begin
                        state_d[i] = ST_COUNT;
                        cnt_d[i]   = IW'(1);
                     end
                  end
               end
               ST_COUNT: begin
                  if (diff[i]) begin
                     state_d[i] = ST_RUN;
                     cnt_d[i]   = '0;
                  end else if (cnt_q[i] == LAST_CNT) begin
                     state_d[i] = ST_GATED;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i]   = cnt_q[i] + IW'(1);
                  end
               end
               ST_GATED: begin
                  if (diff[i]) begin
                     state_d[i] = ST_RUN;
                  end
               end
               default: begin
                  state_d[i] = ST_RUN;
                  cnt_d[i]   = '0;
               end
            endcase
         end
         gated_d[i] = (state_d[i] == ST_GATED);
         wake_d[i]  = (state_q[i] == ST_GATED) && (state_d[i] != ST_GATED);
      end
   end

   // Saturating accumulation of closed lane-cycles; the wide sum cannot overflow before the clamp.
   always_comb begin
      pop = '0;
      for (int i = 0; i < LANES; i++) begin
         if (!EN_OUT[i]) begin
            pop = pop + PW'(1);
         end
      end
      sum    = {{PW{1'b0}}, save_q} + {{CNT_W{1'b0}}, pop};
      save_d = (sum > SAT_VAL) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < LANES; i++) begin
            state_q[i] <= ST_RUN;
            cnt_q[i]   <= '0;
         end
         gated_q <= '0;
         wake_q  <= '0;
         save_q  <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         gated_q <= gated_d;
         wake_q  <= wake_d;
         save_q  <= save_d;
      end
   end

   assign GATED    = gated_q;
   assign WAKE     = wake_q;
   assign SAVE_CNT = save_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: hand vector table, corner sequences and randomized traffic vs a run-length model.
module tb_clk_gate_ctrl;
   localparam int LANES = 5;
   localparam int IDLE  = 4;

   logic             CLK = 1'b0;
   logic             RST_N, FORCE_ON;
   logic [LANES-1:0] D_IN, Q_HELD;
   logic [LANES-1:0] en, gated, wake, en4, gated4, wake4;
   logic [15:0]      save;
   logic [3:0]       save4;

   always #5 CLK = ~CLK;

   clk_gate_ctrl #(.LANES(LANES), .IDLE_CYC(IDLE), .CNT_W(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN), .Q_HELD(Q_HELD), .FORCE_ON(FORCE_ON),
      .EN_OUT(en), .GATED(gated), .WAKE(wake), .SAVE_CNT(save));

   clk_gate_ctrl #(.LANES(LANES), .IDLE_CYC(IDLE), .CNT_W(4)) dut4 (
      .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN), .Q_HELD(Q_HELD), .FORCE_ON(FORCE_ON),
      .EN_OUT(en4), .GATED(gated4), .WAKE(wake4), .SAVE_CNT(save4));

   int checks = 0;
   int errors = 0;

   // Model: per lane, count of consecutive quiet edges since the last change/force/reset.
   int               idle_run [LANES];
   logic [LANES-1:0] wake_m;
   int               sav16, sav4;
   bit               mvalid = 0;
   logic [LANES-1:0] bank;

   typedef struct {
      logic             rst;
      logic             frc;
      logic [LANES-1:0] d;
      logic [LANES-1:0] q;
      logic [LANES-1:0] exp_en;
      logic [LANES-1:0] exp_g;
      logic [LANES-1:0] exp_w;
   } vec_t;
   vec_t tv [21];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [LANES-1:0] model_gated();
      logic [LANES-1:0] g;
      for (int i = 0; i < LANES; i++) g[i] = (idle_run[i] >= IDLE);
      return g;
   endfunction

   function automatic logic [LANES-1:0] model_en();
      return {LANES{~RST_N | FORCE_ON}} | ~model_gated() | (D_IN ^ Q_HELD);
   endfunction

   task automatic cycle(input logic rst, input logic frc, input logic [LANES-1:0] d,
                        input logic [LANES-1:0] q);
      logic [LANES-1:0] e;
      int               closed;
      bit               was;
      RST_N = rst; FORCE_ON = frc; D_IN = d; Q_HELD = q;
      #3;
      e = model_en();
      chk("en_out", en, e);
      chk("en_out_w4", en4, e);
      if (mvalid) begin
         chk("gated", gated, model_gated());
         chk("wake", wake, wake_m);
         chk("save_cnt", save, sav16);
         chk("gated_w4", gated4, model_gated());
         chk("wake_w4", wake4, wake_m);
         chk("save_cnt_w4", save4, sav4);
      end
      @(posedge CLK);
      if (!rst) begin
         for (int i = 0; i < LANES; i++) idle_run[i] = 0;
         wake_m = '0; sav16 = 0; sav4 = 0; mvalid = 1;
      end else begin
         closed = 0;
         for (int i = 0; i < LANES; i++) if (!e[i]) closed++;
         sav16 = (sav16 + closed > 65535) ? 65535 : sav16 + closed;
         sav4  = (sav4 + closed > 15) ? 15 : sav4 + closed;
         for (int i = 0; i < LANES; i++) begin
            was = (idle_run[i] >= IDLE);
            if (frc || d[i] != q[i]) idle_run[i] = 0;
            else if (idle_run[i] < IDLE) idle_run[i]++;
            wake_m[i] = was && (idle_run[i] < IDLE);
         end
      end
      for (int i = 0; i < LANES; i++) if (e[i]) bank[i] = d[i];
      #1;
   endtask

   initial begin
      // rst frc d q en gated wake (registered values seen before that row's edge)
      tv[0]  = '{1, 0, 5'h0A, 5'h0A, 5'h1F, 5'h00, 5'h00};
      tv[1]  = '{1, 0, 5'h0A, 5'h0A, 5'h1F, 5'h00, 5'h00};
      tv[2]  = '{1, 0, 5'h0A, 5'h0A, 5'h1F, 5'h00, 5'h00};
      tv[3]  = '{1, 0, 5'h0A, 5'h0A, 5'h1F, 5'h00, 5'h00};
      tv[4]  = '{1, 0, 5'h0A, 5'h0A, 5'h00, 5'h1F, 5'h00};
      tv[5]  = '{1, 0, 5'h0A, 5'h0A, 5'h00, 5'h1F, 5'h00};
      tv[6]  = '{1, 0, 5'h0E, 5'h0A, 5'h04, 5'h1F, 5'h00};
      tv[7]  = '{1, 0, 5'h0E, 5'h0E, 5'h04, 5'h1B, 5'h04};
      tv[8]  = '{1, 0, 5'h0E, 5'h0E, 5'h04, 5'h1B, 5'h00};
      tv[9]  = '{1, 0, 5'h0E, 5'h0E, 5'h04, 5'h1B, 5'h00};
      tv[10] = '{1, 0, 5'h0E, 5'h0E, 5'h04, 5'h1B, 5'h00};
      tv[11] = '{1, 0, 5'h0E, 5'h0E, 5'h00, 5'h1F, 5'h00};
      tv[12] = '{1, 1, 5'h0E, 5'h0E, 5'h1F, 5'h1F, 5'h00};
      tv[13] = '{1, 1, 5'h0E, 5'h0E, 5'h1F, 5'h00, 5'h1F};
      tv[14] = '{1, 0, 5'h0E, 5'h0E, 5'h1F, 5'h00, 5'h00};
      tv[15] = '{1, 0, 5'h0E, 5'h0E, 5'h1F, 5'h00, 5'h00};
      tv[16] = '{1, 0, 5'h0E, 5'h0E, 5'h1F, 5'h00, 5'h00};
      tv[17] = '{1, 0, 5'h0E, 5'h0E, 5'h1F, 5'h00, 5'h00};
      tv[18] = '{1, 0, 5'h0E, 5'h0E, 5'h00, 5'h1F, 5'h00};
      tv[19] = '{0, 0, 5'h0E, 5'h0E, 5'h1F, 5'h1F, 5'h00};
      tv[20] = '{1, 0, 5'h0E, 5'h0E, 5'h1F, 5'h00, 5'h00};

      RST_N = 1'b0; FORCE_ON = 1'b0; D_IN = '0; Q_HELD = '0; bank = '0;
      @(posedge CLK); #1;
      cycle(1'b0, 1'b0, 5'h0A, 5'h0A);

      for (int k = 0; k < 21; k++) begin
         RST_N = tv[k].rst; FORCE_ON = tv[k].frc; D_IN = tv[k].d; Q_HELD = tv[k].q;
         #2;
         chk("tbl_en", en, tv[k].exp_en);
         chk("tbl_gated", gated, tv[k].exp_g);
         chk("tbl_wake", wake, tv[k].exp_w);
         cycle(tv[k].rst, tv[k].frc, tv[k].d, tv[k].q);
      end

      // Lane 0 toggles every third cycle and must never gate.
      begin
         logic [LANES-1:0] dcur, dprev;
         cycle(1'b0, 1'b0, 5'h10, 5'h10);
         dprev = 5'h10;
         for (int k = 0; k < 15; k++) begin
            dcur = {4'h8, 1'((k / 3) % 2)};
            RST_N = 1'b1; FORCE_ON = 1'b0; D_IN = dcur; Q_HELD = dprev;
            #2;
            chk("toggle_en0", en[0], 1'b1);
            chk("toggle_gated0", gated[0], 1'b0);
            cycle(1'b1, 1'b0, dcur, dprev);
            dprev = dcur;
         end
      end

      // Saturation of the narrow counter with every lane closed.
      cycle(1'b0, 1'b0, 5'h15, 5'h15);
      for (int k = 0; k < 9; k++) begin
         RST_N = 1'b1; FORCE_ON = 1'b0; D_IN = 5'h15; Q_HELD = 5'h15;
         #2;
         if (k == 5) chk("sat_5", save4, 4'd5);
         if (k == 6) chk("sat_10", save4, 4'd10);
         if (k == 7) chk("sat_15", save4, 4'd15);
         if (k == 8) chk("sat_hold", save4, 4'd15);
         if (k == 8) chk("wide_20", save, 16'd20);
         cycle(1'b1, 1'b0, 5'h15, 5'h15);
      end

      // Reset while gated with a non-zero saving count.
      RST_N = 1'b0; FORCE_ON = 1'b0; D_IN = 5'h15; Q_HELD = 5'h15;
      #2;
      chk("rst_en", en, 5'h1F);
      cycle(1'b0, 1'b0, 5'h15, 5'h15);
      chk("rst_gated", gated, 5'h00);
      chk("rst_wake", wake, 5'h00);
      chk("rst_save", save, 16'd0);

      // Randomized traffic with the bank modelled as enabled registers.
      bank = 5'h15;
      for (int k = 0; k < 1500; k++) begin
         logic [LANES-1:0] flips;
         logic             r, f;
         flips = '0;
         for (int i = 0; i < LANES; i++) flips[i] = ($urandom_range(7) == 0);
         r = ($urandom_range(63) != 0);
         f = ($urandom_range(31) == 0);
         cycle(r, f, bank ^ flips, bank);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
